// File: rtl/memory_pkg.sv
// Shared constants and helpers for the dual-port banked memory controller.
package memory_pkg;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SBE  = 2'b01;
    localparam logic [1:0] ERR_DBE  = 2'b10;

    localparam logic [1:0] INJ_NONE = 2'b00;
    localparam logic [1:0] INJ_ONE  = 2'b01;
    localparam logic [1:0] INJ_TWO  = 2'b10;

    localparam int unsigned PORTA     = 0;
    localparam int unsigned PORTB     = 1;
    localparam int unsigned NUM_PORTS = 2;

    // Smallest P with 2**P >= data_w + P + 1; the overall parity bit comes on top.
    function automatic int unsigned ecc_parity_bits(input int unsigned data_w);
        int unsigned p;
        p = 1;
        while ((32'd1 << p) < (data_w + p + 32'd1)) p = p + 1;
        return p;
    endfunction

endpackage

// File: rtl/secded_codec.sv
// Extended-Hamming SECDED encoder (with fault injection) and decoder.
// Codeword bit 0 is overall parity; bits 1..N follow classic Hamming positions.
module secded_codec
    import memory_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned P      = ecc_parity_bits(DATA_W),
    localparam int unsigned CW     = DATA_W + P + 1
) (
    input  logic [DATA_W-1:0] enc_data,
    input  logic [1:0]        enc_inj,
    output logic [CW-1:0]     enc_word_c,
    input  logic [CW-1:0]     dec_word,
    output logic [DATA_W-1:0] dec_data_c,
    output logic [1:0]        dec_err_c
);

    localparam int unsigned N = DATA_W + P;

    // Positions covered by check bit 2**bit_idx.
    function automatic logic [CW-1:0] cover_mask(input int unsigned bit_idx);
        logic [CW-1:0] m;
        m = '0;
        for (int unsigned pos = 1; pos <= N; pos++) m[pos] = pos[bit_idx];
        return m;
    endfunction

    // Data bits occupy every non-power-of-two position, in ascending order.
    function automatic logic [CW-1:0] scatter(input logic [DATA_W-1:0] d);
        logic [CW-1:0] w;
        int unsigned   k;
        w = '0;
        k = 0;
        for (int unsigned pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[k];
                k      = k + 1;
            end
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] gather(input logic [CW-1:0] w);
        logic [DATA_W-1:0] d;
        int unsigned       k;
        d = '0;
        k = 0;
        for (int unsigned pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = w[pos];
                k    = k + 1;
            end
        end
        return d;
    endfunction

    logic [CW-1:0] enc_w;
    logic [CW-1:0] enc_flip;

    // Encode: fill check bits, then overall parity, then apply the test flip.
    always_comb begin
        enc_w = scatter(enc_data);
        for (int unsigned i = 0; i < P; i++) enc_w[32'd1 << i] = ^(enc_w & cover_mask(i));
        enc_w[0] = ^enc_w[CW-1:1];
        enc_flip = '0;
        if (enc_inj == INJ_ONE)      enc_flip[0]   = 1'b1;
        else if (enc_inj == INJ_TWO) enc_flip[1:0] = 2'b11;
        enc_word_c = enc_w ^ enc_flip;
    end

    logic [P-1:0]  syn;
    logic          overall;
    logic [CW-1:0] fixed;

    // Decode: odd overall parity means a single (correctable) error; a nonzero
    // syndrome with even parity, or one pointing past the word, is a double error.
    always_comb begin
        syn = '0;
        for (int unsigned i = 0; i < P; i++) syn[i] = ^(dec_word & cover_mask(i));
        overall   = ^dec_word;
        fixed     = dec_word;
        dec_err_c = ERR_NONE;
        if (overall) begin
            if (32'(syn) <= N) begin
                fixed[syn] = ~fixed[syn];
                dec_err_c  = ERR_SBE;
            end else begin
                dec_err_c = ERR_DBE;
            end
        end else if (syn != '0) begin
            dec_err_c = ERR_DBE;
        end
        dec_data_c = gather(fixed);
    end

endmodule

// File: rtl/memory_top.sv
// Dual-port multibank RAM controller with per-port write/read latency
// pipelines and optional SECDED protection of the stored words.
module memory_top
    import memory_pkg::*;
#(
    parameter int unsigned WR_LATENCYA = 2,
    parameter int unsigned WR_LATENCYB = 2,
    parameter int unsigned RD_LATENCYA = 2,
    parameter int unsigned RD_LATENCYB = 2,
    parameter int unsigned DATA_A      = 32,
    parameter int unsigned ADDR_A      = 8,
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned ECC_EN      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ena,
    input  logic              i_enb,
    input  logic              i_wea,
    input  logic              i_web,
    input  logic [ADDR_A-1:0] i_addra,
    input  logic [ADDR_A-1:0] i_addrb,
    input  logic [DATA_A-1:0] i_data_in_a,
    input  logic [DATA_A-1:0] i_data_in_b,
    input  logic [1:0]        i_err_inj_a,
    input  logic [1:0]        i_err_inj_b,
    output logic [DATA_A-1:0] o_dout_a,
    output logic [DATA_A-1:0] o_dout_b,
    output logic [1:0]        o_errora,
    output logic [1:0]        o_errorb
);

    localparam int unsigned P          = ecc_parity_bits(DATA_A);
    localparam int unsigned SW         = (ECC_EN != 0) ? DATA_A + P + 1 : DATA_A;
    localparam int unsigned LOG_B      = $clog2(NUM_BANKS);
    localparam int unsigned BANK_W     = (LOG_B > 0) ? LOG_B : 1;
    localparam int unsigned ROW_W      = (ADDR_A > LOG_B) ? ADDR_A - LOG_B : 1;
    localparam int unsigned BANK_DEPTH = 32'd1 << (ADDR_A - LOG_B);

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_A-1:0] a);
        return (LOG_B > 0) ? BANK_W'(a) : '0;
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_A-1:0] a);
        return ROW_W'(a >> LOG_B);
    endfunction

    logic              req_en   [NUM_PORTS];
    logic              req_we   [NUM_PORTS];
    logic [ADDR_A-1:0] req_addr [NUM_PORTS];
    logic [DATA_A-1:0] req_data [NUM_PORTS];
    logic [1:0]        req_inj  [NUM_PORTS];

    logic              cmt_v    [NUM_PORTS];
    logic [ADDR_A-1:0] cmt_addr [NUM_PORTS];
    logic [SW-1:0]     cmt_word [NUM_PORTS];
    logic [DATA_A-1:0] dout_q   [NUM_PORTS];
    logic [1:0]        err_q    [NUM_PORTS];

    logic [SW-1:0] mem [NUM_BANKS][BANK_DEPTH];

    assign req_en[PORTA]   = i_ena;
    assign req_en[PORTB]   = i_enb;
    assign req_we[PORTA]   = i_wea;
    assign req_we[PORTB]   = i_web;
    assign req_addr[PORTA] = i_addra;
    assign req_addr[PORTB] = i_addrb;
    assign req_data[PORTA] = i_data_in_a;
    assign req_data[PORTB] = i_data_in_b;
    assign req_inj[PORTA]  = i_err_inj_a;
    assign req_inj[PORTB]  = i_err_inj_b;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam int unsigned WL = (p == PORTA) ? WR_LATENCYA : WR_LATENCYB;
        localparam int unsigned RL = (p == PORTA) ? RD_LATENCYA : RD_LATENCYB;

        logic              wr_v    [WL];
        logic [ADDR_A-1:0] wr_addr [WL];
        logic [DATA_A-1:0] wr_data [WL];
        logic [1:0]        wr_inj  [WL];

        // Write pipeline; the last stage commits to the array on the next edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned k = 0; k < WL; k++) begin
                    wr_v[k]    <= 1'b0;
                    wr_addr[k] <= '0;
                    wr_data[k] <= '0;
                    wr_inj[k]  <= INJ_NONE;
                end
            end else begin
                wr_v[0]    <= req_en[p] & req_we[p];
                wr_addr[0] <= req_addr[p];
                wr_data[0] <= req_data[p];
                wr_inj[0]  <= req_inj[p];
                for (int unsigned k = 1; k < WL; k++) begin
                    wr_v[k]    <= wr_v[k-1];
                    wr_addr[k] <= wr_addr[k-1];
                    wr_data[k] <= wr_data[k-1];
                    wr_inj[k]  <= wr_inj[k-1];
                end
            end
        end

        logic          rd_v    [RL];
        logic [SW-1:0] rd_word [RL];

        // Read pipeline; stage 0 captures the array as it was before the accept edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned k = 0; k < RL; k++) begin
                    rd_v[k]    <= 1'b0;
                    rd_word[k] <= '0;
                end
            end else begin
                rd_v[0] <= req_en[p] & ~req_we[p];
                if (req_en[p] && !req_we[p]) begin
                    rd_word[0] <= mem[bank_of(req_addr[p])][row_of(req_addr[p])];
                end
                for (int unsigned k = 1; k < RL; k++) begin
                    rd_v[k]    <= rd_v[k-1];
                    rd_word[k] <= rd_word[k-1];
                end
            end
        end

        logic [SW-1:0]     enc_word;
        logic [DATA_A-1:0] dec_data;
        logic [1:0]        dec_err;

        if (ECC_EN != 0) begin : g_ecc
            secded_codec #(
                .DATA_W (DATA_A)
            ) u_codec (
                .enc_data   (wr_data[WL-1]),
                .enc_inj    (wr_inj[WL-1]),
                .enc_word_c (enc_word),
                .dec_word   (rd_word[RL-1]),
                .dec_data_c (dec_data),
                .dec_err_c  (dec_err)
            );
        end else begin : g_raw
            assign enc_word = wr_data[WL-1];
            assign dec_data = rd_word[RL-1];
            assign dec_err  = ERR_NONE;
        end

        logic [DATA_A-1:0] dout_r;
        logic [1:0]        err_r;

        // Output registers hold until the next read result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_r <= '0;
                err_r  <= ERR_NONE;
            end else if (rd_v[RL-1]) begin
                dout_r <= dec_data;
                err_r  <= dec_err;
            end
        end

        assign cmt_v[p]    = wr_v[WL-1];
        assign cmt_addr[p] = wr_addr[WL-1];
        assign cmt_word[p] = enc_word;
        assign dout_q[p]   = dout_r;
        assign err_q[p]    = err_r;
    end

    // Array commit; port A is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (cmt_v[PORTB]) mem[bank_of(cmt_addr[PORTB])][row_of(cmt_addr[PORTB])] <= cmt_word[PORTB];
        if (cmt_v[PORTA]) mem[bank_of(cmt_addr[PORTA])][row_of(cmt_addr[PORTA])] <= cmt_word[PORTA];
    end

    assign o_dout_a = dout_q[PORTA];
    assign o_dout_b = dout_q[PORTB];
    assign o_errora = err_q[PORTA];
    assign o_errorb = err_q[PORTB];

endmodule

// File: tb/tb_memory_top.sv
// Scoreboard bench for memory_top: a timed reference model predicts each read
// at accept time and the result is compared when its latency has elapsed.
module tb_memory_top;
    import memory_pkg::*;

    localparam int unsigned WA = 2;
    localparam int unsigned WB = 2;
    localparam int unsigned RA = 2;
    localparam int unsigned RB = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0, enb = 1'b0, wea = 1'b0, web = 1'b0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [DW-1:0] dina = '0, dinb = '0;
    logic [1:0]    inja = 2'b00, injb = 2'b00;
    logic [DW-1:0] o_dout_a, o_dout_b;
    logic [1:0]    o_errora, o_errorb;

    always #5 clk = ~clk;

    memory_top #(
        .WR_LATENCYA (WA), .WR_LATENCYB (WB),
        .RD_LATENCYA (RA), .RD_LATENCYB (RB),
        .DATA_A (DW), .ADDR_A (AW), .NUM_BANKS (NB), .ECC_EN (1)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .i_ena (ena), .i_enb (enb), .i_wea (wea), .i_web (web),
        .i_addra (addra), .i_addrb (addrb),
        .i_data_in_a (dina), .i_data_in_b (dinb),
        .i_err_inj_a (inja), .i_err_inj_b (injb),
        .o_dout_a (o_dout_a), .o_dout_b (o_dout_b),
        .o_errora (o_errora), .o_errorb (o_errorb)
    );

    typedef struct {
        int unsigned   due;
        int unsigned   port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    inj;
    } wr_t;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
        logic [1:0]    err;
    } exp_t;

    wr_t           pend[$];
    exp_t          exp_a[$];
    exp_t          exp_b[$];
    logic [DW-1:0] model_mem [2**AW];
    logic [1:0]    model_err [2**AW];
    int unsigned   cyc = 0;
    int unsigned   n_checks = 0;
    int unsigned   n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [1:0] err_of(input logic [1:0] inj);
        if (inj == 2'b01) return ERR_SBE;
        if (inj == 2'b10) return ERR_DBE;
        return ERR_NONE;
    endfunction

    task automatic commit_port(input int unsigned port);
        foreach (pend[i]) begin
            if (pend[i].due == cyc && pend[i].port == port) begin
                model_mem[pend[i].addr] = pend[i].data;
                model_err[pend[i].addr] = err_of(pend[i].inj);
            end
        end
    endtask

    // One clock: model what the edge accepts/commits, then check due results.
    task automatic tick();
        exp_t e;
        wr_t  w;
        wr_t  keep[$];
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (ena && !wea) begin
                e.due = cyc + RA; e.data = model_mem[addra]; e.err = model_err[addra];
                exp_a.push_back(e);
            end
            if (enb && !web) begin
                e.due = cyc + RB; e.data = model_mem[addrb]; e.err = model_err[addrb];
                exp_b.push_back(e);
            end
            commit_port(PORTB);
            commit_port(PORTA);
            foreach (pend[i]) if (pend[i].due != cyc) keep.push_back(pend[i]);
            pend = keep;
            if (ena && wea) begin
                w.due = cyc + WA; w.port = PORTA; w.addr = addra; w.data = dina; w.inj = inja;
                pend.push_back(w);
            end
            if (enb && web) begin
                w.due = cyc + WB; w.port = PORTB; w.addr = addrb; w.data = dinb; w.inj = injb;
                pend.push_back(w);
            end
        end
        @(negedge clk);
        while (exp_a.size() > 0 && exp_a[0].due <= cyc) begin
            e = exp_a.pop_front();
            chk("rd_a data", o_dout_a, e.data);
            chk("rd_a err", DW'(o_errora), DW'(e.err));
        end
        while (exp_b.size() > 0 && exp_b[0].due <= cyc) begin
            e = exp_b.pop_front();
            chk("rd_b data", o_dout_b, e.data);
            chk("rd_b err", DW'(o_errorb), DW'(e.err));
        end
        ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0; inja = 2'b00; injb = 2'b00;
    endtask

    task automatic set_a(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] inj);
        ena = 1'b1; wea = we; addra = a; dina = d; inja = inj;
    endtask

    task automatic set_b(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] inj);
        enb = 1'b1; web = we; addrb = a; dinb = d; injb = inj;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " dout_a"}, o_dout_a, '0);
        chk({tag, " dout_b"}, o_dout_b, '0);
        chk({tag, " err_a"}, DW'(o_errora), '0);
        chk({tag, " err_b"}, DW'(o_errorb), '0);
    endtask

    initial begin
        logic [DW-1:0] prev;
        int unsigned   span, off_a, off_b, last;

        // Power-on reset state
        idle(2);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Reset mid-stream drops an in-flight write and an in-flight read
        set_a(1'b1, 8'h20, 32'h1111_1111, 2'b00); tick();
        idle(WA + 1);
        set_a(1'b0, 8'h20, '0, 2'b00); tick();
        idle(RA);
        set_a(1'b1, 8'h20, 32'h2222_2222, 2'b00);
        set_b(1'b0, 8'h20, '0, 2'b00);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid rst");
        pend.delete(); exp_a.delete(); exp_b.delete();
        idle(2);
        rst_n = 1'b1;
        idle(WA + 1);
        set_a(1'b0, 8'h20, '0, 2'b00); tick();
        idle(RA);

        // Read latency: output holds until exactly RA edges after accept
        set_a(1'b1, 8'h10, 32'hDEAD_BEEF, 2'b00); tick();
        idle(WA);
        prev = o_dout_a;
        set_a(1'b0, 8'h10, '0, 2'b00); tick();
        for (int unsigned k = 0; k < RA; k++) begin
            chk("hold dout_a", o_dout_a, prev);
            tick();
        end
        chk("latency dout_a", o_dout_a, 32'hDEAD_BEEF);

        // Read-after-write boundary across ports
        set_a(1'b1, 8'h05, 32'h0000_0001, 2'b00); tick();
        idle(WA);
        set_a(1'b1, 8'h05, 32'h0000_0077, 2'b00); tick();
        idle(WA - 1);
        set_b(1'b0, 8'h05, '0, 2'b00); tick();
        set_b(1'b0, 8'h05, '0, 2'b00); tick();
        idle(RB);

        // Same-address collision with commits on the same edge
        span  = (WA > WB) ? WA : WB;
        off_a = span - WA;
        off_b = span - WB;
        last  = (off_a > off_b) ? off_a : off_b;
        for (int unsigned k = 0; k <= last; k++) begin
            if (k == off_a) set_a(1'b1, 8'h03, 32'h0000_AAAA, 2'b00);
            if (k == off_b) set_b(1'b1, 8'h03, 32'h0000_5555, 2'b00);
            tick();
        end
        idle(span + 1);
        set_a(1'b0, 8'h03, '0, 2'b00);
        set_b(1'b0, 8'h03, '0, 2'b00);
        tick();
        idle(RA + RB);
        chk("collision dout_a", o_dout_a, 32'h0000_AAAA);
        chk("collision dout_b", o_dout_b, 32'h0000_AAAA);

        // ECC injection: single flip corrected, double flip detected
        set_a(1'b1, 8'h40, 32'h1234_5678, 2'b01);
        set_b(1'b1, 8'h41, 32'h1234_5678, 2'b10);
        tick();
        idle(span + 1);
        set_a(1'b0, 8'h40, '0, 2'b00); set_b(1'b0, 8'h41, '0, 2'b00); tick();
        set_a(1'b0, 8'h41, '0, 2'b00); set_b(1'b0, 8'h40, '0, 2'b00); tick();
        idle(RA + RB);

        // Bank sweep: fill via alternating ports, read everything back from both
        for (int unsigned a = 0; a < 2**AW; a += 2) begin
            set_a(1'b1, AW'(a), DW'(a * 3), 2'b00);
            set_b(1'b1, AW'(a + 1), DW'((a + 1) * 3), 2'b00);
            tick();
        end
        idle(span + 1);
        for (int unsigned a = 0; a < 2**AW; a++) begin
            set_a(1'b0, AW'(a), '0, 2'b00);
            set_b(1'b0, AW'(2**AW - 1 - a), '0, 2'b00);
            tick();
        end

        for (int unsigned k = 0; k < 16 && (exp_a.size() + exp_b.size()) > 0; k++) tick();
        chk("scoreboard drained", DW'(exp_a.size() + exp_b.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
